// File: rtl/cb_sequencer_pkg.sv
// cb_sequencer_pkg: shared opcode field codes, operation classes and cycle counts for the CB sequencer
package cb_sequencer_pkg;
  localparam logic [1:0] GRP_ROTSHIFT = 2'b00;
  localparam logic [1:0] GRP_BIT = 2'b01;
  localparam logic [1:0] GRP_RES = 2'b10;
  localparam logic [1:0] GRP_SET = 2'b11;
  localparam logic [2:0] ROT_RLC = 3'd0;
  localparam logic [2:0] ROT_RRC = 3'd1;
  localparam logic [2:0] ROT_RL = 3'd2;
  localparam logic [2:0] ROT_RR = 3'd3;
  localparam logic [2:0] ROT_SLA = 3'd4;
  localparam logic [2:0] ROT_SRA = 3'd5;
  localparam logic [2:0] ROT_SWAP = 3'd6;
  localparam logic [2:0] ROT_SRL = 3'd7;
  localparam logic [1:0] CYCLES_REG = 2'd1;
  localparam logic [1:0] CYCLES_HLRMW = 2'd3;
  localparam logic [1:0] CYCLES_HLBIT = 2'd2;
  typedef enum logic [1:0] {CLS_IDLE, CLS_REG, CLS_HLRMW, CLS_HLBIT} op_class_t;
  // Memory operand selects (HL) forms; BIT on (HL) skips the write-back cycle.
  function automatic op_class_t decode_class(input logic [7:0] op, input logic [2:0] hl_index);
    return op[2:0] != hl_index ? CLS_REG : op[7:6] == GRP_BIT ? CLS_HLBIT : CLS_HLRMW;
  endfunction
  // Index of the final M-cycle for a class.
  function automatic logic [1:0] last_cycle(input op_class_t c);
    return c == CLS_HLRMW ? CYCLES_HLRMW - 2'd1 : c == CLS_HLBIT ? CYCLES_HLBIT - 2'd1 : CYCLES_REG - 2'd1;
  endfunction
endpackage

// File: rtl/cb_step_counter.sv
// cb_step_counter: one-hot T-step ring with M-cycle counter, start/stop/hold control
module cb_step_counter #(
  parameter int STEPS = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             stop,
  input  logic             hold,
  output logic [STEPS-1:0] step,
  output logic [1:0]       cycle
);
  // Start forces step0/cycle0, stop empties the ring, otherwise rotate and bump cycle on wrap.
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      step <= '0;
      cycle <= '0;
    end else if (start) begin
      step <= {{(STEPS-1){1'b0}}, 1'b1};
      cycle <= '0;
    end else if (stop) begin
      step <= '0;
      cycle <= '0;
    end else if (!hold && step != '0) begin
      step <= {step[STEPS-2:0], step[STEPS-1]};
      cycle <= cycle + {1'b0, step[STEPS-1]};
    end
endmodule

// File: rtl/cb_sequencer.sv
// cb_sequencer: clocked CB-prefix microsequencer driving register, ALU, bus and fetch strobes
module cb_sequencer
  import cb_sequencer_pkg::*;
#(
  parameter int REG_COUNT = 8,
  parameter int HL_INDEX = 6,
  parameter int STEPS = 4,
  parameter int ALU_OP_W = 5
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [7:0]           opcode,
  input  logic                 stall,
  output logic                 busy,
  output logic                 done,
  output logic [STEPS-1:0]     step,
  output logic [1:0]           cycle,
  output logic [REG_COUNT-1:0] read8,
  output logic [REG_COUNT-1:0] write8,
  output logic                 temp_read,
  output logic                 temp_write,
  output logic                 read16_hl,
  output logic                 address_out,
  output logic                 bus_in,
  output logic                 bus_out,
  output logic [ALU_OP_W-1:0]  alu_op,
  output logic                 alu_step,
  output logic                 ir_fetch,
  output logic                 disable_cb
);
  localparam logic [2:0] HL = 3'(HL_INDEX);
  op_class_t cls, cls_next;
  logic [7:0] op;
  logic accept, hl, rmw, hold;
  // Latch the opcode and its class on accept; return to idle after the final step.
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      cls <= CLS_IDLE;
      op <= '0;
    end else begin
      cls <= cls_next;
      if (accept) op <= opcode;
    end
  // Next-state and strobe decode from the registered class, step and cycle.
  always_comb begin
    busy = cls != CLS_IDLE;
    hl = cls == CLS_HLRMW || cls == CLS_HLBIT;
    rmw = cls == CLS_HLRMW;
    done = busy && step[STEPS-1] && cycle == last_cycle(cls);
    accept = start && (!busy || done);
    cls_next = accept ? decode_class(opcode, HL) : done ? CLS_IDLE : cls;
    read8 = cls == CLS_REG && step[1] ? REG_COUNT'(1) << op[2:0] : '0;
    write8 = cls == CLS_REG && step[2] && op[7:6] != GRP_BIT ? REG_COUNT'(1) << op[2:0] : '0;
    read16_hl = hl && step[0] && (cycle == 2'd0 || (rmw && cycle == 2'd1));
    address_out = read16_hl;
    bus_in = hl && step[0] && cycle == 2'd0;
    bus_out = rmw && step[0] && cycle == 2'd1;
    temp_write = bus_in || (rmw && step[2] && cycle == 2'd0);
    temp_read = (hl && step[1] && cycle == 2'd0) || bus_out;
    alu_step = busy && step[2] && cycle == 2'd0;
    ir_fetch = done;
    disable_cb = done;
    alu_op = ALU_OP_W'(op[7:3]);
    hold = stall && address_out;
  end
  cb_step_counter #(.STEPS(STEPS)) u_step (
    .clk(clk),
    .rst_n(rst_n),
    .start(accept),
    .stop(done && !accept),
    .hold(hold),
    .step(step),
    .cycle(cycle)
  );
endmodule

// File: tb/tb_cb_sequencer.sv
// tb_cb_sequencer: directed self-checking bench for cb_sequencer (STEPS=4 and STEPS=6 builds)
module tb_cb_sequencer;
  logic clk = 1'b0, rst_n = 1'b0, start = 1'b0, stall = 1'b0, start6 = 1'b0;
  logic [7:0] opcode = '0, opcode6 = '0;
  logic busy, done, temp_read, temp_write, read16_hl, address_out, bus_in, bus_out, alu_step, ir_fetch, disable_cb;
  logic [3:0] step;
  logic [1:0] cycle;
  logic [7:0] read8, write8;
  logic [4:0] alu_op;
  logic busy6, done6, temp_read6, temp_write6, read16_hl6, address_out6, bus_in6, bus_out6, alu_step6, ir_fetch6, disable_cb6;
  logic [5:0] step6;
  logic [1:0] cycle6;
  logic [7:0] read8_6, write8_6;
  logic [4:0] alu_op6;
  logic [9:0] sb, sb6;
  int total = 0, passed = 0;
  localparam logic [9:0] HLBIT_SB [8] = '{10'h390, 10'h020, 10'h008, 10'h000, 10'h000, 10'h000, 10'h000, 10'h007};
  localparam logic [9:0] SET_SB [15] = '{10'h390, 10'h020, 10'h018, 10'h000, 10'h360, 10'h360, 10'h360, 10'h360,
                                         10'h000, 10'h000, 10'h000, 10'h000, 10'h000, 10'h000, 10'h007};
  localparam int SET_SIDX [15] = '{0, 1, 2, 3, 0, 0, 0, 0, 1, 2, 3, 0, 1, 2, 3};
  localparam int SET_CYC [15] = '{0, 0, 0, 0, 1, 1, 1, 1, 1, 1, 1, 2, 2, 2, 2};
  localparam logic [9:0] S6_SB [6] = '{10'h000, 10'h000, 10'h008, 10'h000, 10'h000, 10'h007};
  assign sb = {read16_hl, address_out, bus_in, bus_out, temp_read, temp_write, alu_step, ir_fetch, disable_cb, done};
  assign sb6 = {read16_hl6, address_out6, bus_in6, bus_out6, temp_read6, temp_write6, alu_step6, ir_fetch6, disable_cb6, done6};
  always #5 clk = ~clk;
  cb_sequencer u_dut (
    .clk(clk), .rst_n(rst_n), .start(start), .opcode(opcode), .stall(stall),
    .busy(busy), .done(done), .step(step), .cycle(cycle), .read8(read8), .write8(write8),
    .temp_read(temp_read), .temp_write(temp_write), .read16_hl(read16_hl), .address_out(address_out),
    .bus_in(bus_in), .bus_out(bus_out), .alu_op(alu_op), .alu_step(alu_step),
    .ir_fetch(ir_fetch), .disable_cb(disable_cb)
  );
  cb_sequencer #(.STEPS(6)) u_dut6 (
    .clk(clk), .rst_n(rst_n), .start(start6), .opcode(opcode6), .stall(1'b0),
    .busy(busy6), .done(done6), .step(step6), .cycle(cycle6), .read8(read8_6), .write8(write8_6),
    .temp_read(temp_read6), .temp_write(temp_write6), .read16_hl(read16_hl6), .address_out(address_out6),
    .bus_in(bus_in6), .bus_out(bus_out6), .alu_op(alu_op6), .alu_step(alu_step6),
    .ir_fetch(ir_fetch6), .disable_cb(disable_cb6)
  );
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  initial begin
    repeat (2) @(posedge clk);
    #1;
    chk("reset busy", busy, 0);
    chk("reset step", step, 0);
    chk("reset cycle", cycle, 0);
    chk("reset strobes", sb, 0);
    chk("reset regsel", {read8, write8}, 0);
    chk("reset alu_op", alu_op, 0);
    chk("reset step6", step6, 0);
    rst_n = 1'b1;
    start = 1'b1; opcode = 8'h11; tick; start = 1'b0;
    chk("rl busy", busy, 1);
    chk("rl s0 step", step, 4'b0001);
    chk("rl alu_op", alu_op, 5'h02);
    chk("rl s0 strobes", sb, 0);
    tick;
    chk("rl s1 step", step, 4'b0010);
    chk("rl s1 read8", read8, 8'h02);
    chk("rl s1 write8", write8, 0);
    tick;
    chk("rl s2 write8", write8, 8'h02);
    chk("rl s2 read8", read8, 0);
    chk("rl s2 strobes", sb, 10'h008);
    tick;
    chk("rl s3 step", step, 4'b1000);
    chk("rl s3 strobes", sb, 10'h007);
    tick;
    chk("rl idle busy", busy, 0);
    chk("rl idle step", step, 0);
    chk("rl idle strobes", sb, 0);
    start = 1'b1; opcode = 8'h46; tick; start = 1'b0;
    chk("bit alu_op", alu_op, 5'h08);
    for (int k = 0; k < 8; k++) begin
      chk($sformatf("bit k%0d step", k), step, 1 << (k % 4));
      chk($sformatf("bit k%0d cycle", k), cycle, k / 4);
      chk($sformatf("bit k%0d strobes", k), sb, HLBIT_SB[k]);
      chk($sformatf("bit k%0d write8", k), write8, 0);
      tick;
    end
    chk("bit idle busy", busy, 0);
    start = 1'b1; opcode = 8'hFE; tick; start = 1'b0;
    chk("set alu_op", alu_op, 5'h1F);
    for (int k = 1; k <= 15; k++) begin
      chk($sformatf("set c%0d strobes", k), sb, SET_SB[k-1]);
      chk($sformatf("set c%0d step", k), step, 1 << SET_SIDX[k-1]);
      chk($sformatf("set c%0d cycle", k), cycle, SET_CYC[k-1]);
      stall = (k == 2) || (k >= 5 && k <= 7);
      tick;
    end
    stall = 1'b0;
    chk("set idle busy", busy, 0);
    start = 1'b1; opcode = 8'h37; tick; start = 1'b0;
    chk("swap alu_op", alu_op, 5'h06);
    chk("swap s0 step", step, 4'b0001);
    tick;
    chk("swap s1 read8", read8, 8'h80);
    start = 1'b1; opcode = 8'hFF; tick; start = 1'b0;
    chk("swap s2 write8", write8, 8'h80);
    chk("swap ignore alu_op", alu_op, 5'h06);
    chk("swap s2 step", step, 4'b0100);
    tick;
    chk("swap s3 strobes", sb, 10'h007);
    start = 1'b1; opcode = 8'h80; tick; start = 1'b0;
    chk("res b2b step", step, 4'b0001);
    chk("res b2b cycle", cycle, 0);
    chk("res b2b busy", busy, 1);
    chk("res alu_op", alu_op, 5'h10);
    chk("res s0 strobes", sb, 0);
    tick;
    chk("res s1 read8", read8, 8'h01);
    tick;
    chk("res s2 write8", write8, 8'h01);
    start = 1'b1; opcode = 8'h46; tick; start = 1'b0;
    chk("res s3 strobes", sb, 10'h007);
    chk("res ignore alu_op", alu_op, 5'h10);
    tick;
    chk("res idle busy", busy, 0);
    chk("res idle step", step, 0);
    start = 1'b1; opcode = 8'hFE; tick; start = 1'b0;
    repeat (6) tick;
    chk("rst pre cycle", cycle, 1);
    chk("rst pre step", step, 4'b0100);
    #2 rst_n = 1'b0;
    #1;
    chk("rst async busy", busy, 0);
    chk("rst async step", step, 0);
    chk("rst async cycle", cycle, 0);
    chk("rst async strobes", sb, 0);
    chk("rst async alu_op", alu_op, 0);
    tick;
    rst_n = 1'b1;
    start = 1'b1; opcode = 8'h11; tick; start = 1'b0;
    chk("rst restart step", step, 4'b0001);
    chk("rst restart cycle", cycle, 0);
    chk("rst restart busy", busy, 1);
    tick;
    chk("rst restart read8", read8, 8'h02);
    repeat (3) tick;
    chk("rst restart idle", busy, 0);
    start6 = 1'b1; opcode6 = 8'h00; tick; start6 = 1'b0;
    chk("s6 alu_op", alu_op6, 0);
    for (int k = 0; k < 6; k++) begin
      chk($sformatf("s6 k%0d step", k), step6, 1 << k);
      chk($sformatf("s6 k%0d strobes", k), sb6, S6_SB[k]);
      chk($sformatf("s6 k%0d read8", k), read8_6, k == 1 ? 8'h01 : 8'h00);
      chk($sformatf("s6 k%0d write8", k), write8_6, k == 2 ? 8'h01 : 8'h00);
      tick;
    end
    chk("s6 idle busy", busy6, 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/cb_sequencer.md
Name: cb_sequencer

Overview:
- Clocked successor to the combinational CB-prefix microcode decoder; owns its own M-cycle/T-step counters instead of consuming externally supplied ones.
- Latches the CB opcode on start, then sequences register-form, (HL) read-modify-write and short (HL) BIT operations.
- Drives register-file, ALU, bus and IR-fetch strobes toward the control unit's strobe merge.
- Sits beside the main opcode microcode, enabled after the 0xCB prefix fetch.

Parameters:
- REG_COUNT, 8, width of one-hot register read/write selects (operand field index maps 1:1 to select bit).
- HL_INDEX, 6, operand field value meaning memory at (HL); its select bit is never driven.
- STEPS, 4, T-steps per M-cycle; o_Step is one-hot of this width. Minimum 4.
- ALU_OP_W, 5, width of the ALU operation code.

Ports:
- i_Clk  in  1  system clock
- i_Reset_n  in  1  asynchronous active-low reset
- i_Start  in  1  opcode byte valid after CB prefix; sampled when accepting
- i_Opcode  in  8  CB opcode byte
- i_Stall  in  1  memory wait; freezes the sequencer
- o_Busy  out  1  operation in progress
- o_Done  out  1  one-clock pulse on the final step of an operation
- o_Step  out  STEPS  one-hot current T-step
- o_Cycle  out  2  current M-cycle index within the operation
- o_Read8  out  REG_COUNT  one-hot register-to-ALU read
- o_Write8  out  REG_COUNT  one-hot ALU-to-register write
- o_Temp_Read / o_Temp_Write  out  1 each  memory temp register read/write
- o_Read16_HL  out  1  HL onto address bus
- o_Address_Out, o_Bus_In, o_Bus_Out  out  1 each  bus strobes
- o_ALU_Op  out  ALU_OP_W  {group[1:0], sub-op[2:0]} = i_Opcode[7:3] latched
- o_ALU_Step  out  1  ALU evaluate/commit strobe (BIT: flags only)
- o_IR_Fetch, o_Disable_CB  out  1 each  next-opcode fetch; leave CB mode

Behaviour:
- Reset (async, any state): state IDLE, o_Step=0, o_Cycle=0; every strobe, o_Busy and o_Done = 0; latched opcode cleared to 0x00.
- Accept: i_Start in IDLE, or on the clock where o_Done=1 (back-to-back). Opcode is latched; step0 of cycle0 begins on the next clock. i_Start while busy and not done is ignored.
- Class decode on the latched opcode:
  - REG: operand field != HL_INDEX.
  - HLBIT: field == HL_INDEX and group == 01.
  - HLRMW: field == HL_INDEX and group != 01.
- REG, 1 M-cycle:
  - step1: o_Read8[field].
  - step2: o_ALU_Step; o_Write8[field] unless group 01.
  - step3: o_IR_Fetch, o_Disable_CB, o_Done.
- HLRMW, 3 M-cycles:
  - C0 step0: o_Read16_HL, o_Address_Out, o_Bus_In, o_Temp_Write. Step1: o_Temp_Read. Step2: o_ALU_Step, o_Temp_Write.
  - C1 step0: o_Read16_HL, o_Address_Out, o_Bus_Out, o_Temp_Read.
  - C2 step3: o_IR_Fetch, o_Disable_CB, o_Done.
- HLBIT, 2 M-cycles: C0 identical to HLRMW C0, but step2 asserts no o_Temp_Write. C1 step3: fetch, disable and done.
- Step counter: advances one-hot every clock and wraps step(STEPS-1) to step0 with o_Cycle+1. Steps 4..STEPS-1, when STEPS>4, carry no strobes except on the final step.
- Stall: when i_Stall=1 during a step0 that drives o_Address_Out, step and cycle hold and strobes stay asserted. Stall is ignored elsewhere.
- Strobes are combinational from the registered state; no strobe is asserted in IDLE.
- o_Busy = 1 from the first step0 through the o_Done clock inclusive.

Decomposition:
- Shared package holds:
  - group codes (ROTSHIFT=00, BIT=01, RES=10, SET=11);
  - rotate sub-op codes;
  - class enum {IDLE, REG, HLRMW, HLBIT};
  - per-class M-cycle counts (1/3/2).
- One natural sub-module: cb_step_counter (one-hot step ring plus cycle counter with hold/clear). Strobe decode stays in cb_sequencer.

Test Plan:
- Reset mid-HLRMW (cycle1, step2), pulse i_Reset_n low -> all outputs 0 immediately (asynchronous), o_Busy=0; the next i_Start begins cleanly at step0.
- Start with 0x11 (RL C) -> 4 clocks. o_Read8=0x02 at step1; o_Write8=0x02 with o_ALU_Step at step2; o_IR_Fetch, o_Disable_CB and o_Done at step3; o_ALU_Op=0x02.
- Start with 0x46 (BIT 0,(HL)) -> 8 clocks. C0: bus read and ALU step with o_Temp_Write=0 at step2. o_Write8 stays 0 throughout; o_Done at cycle1 step3.
- Start with 0xFE (SET 7,(HL)), i_Stall=1 for 3 clocks at C1 step0 -> o_Bus_Out held 4 clocks total; o_Done at clock 15 after accept.
- Start with 0x37 (SWAP A) and assert i_Start with 0x80 (RES 0,B) on the o_Done clock -> second op's step0 follows immediately; o_Read8=0x01 at its step1. A third i_Start mid-op is ignored.
- STEPS=6 build, 0x00 (RLC B) -> 6 clocks; strobes on steps 1, 2 and 5 only.
